// File: rtl/med_pkg.sv
// ----------------------------------------------------------------------------
// med_pkg
// Shared types and defaults for the multi-channel event detector.
//   det_mode_e : per-channel detection mode (HIGH, RISE, FALL, BOTH)
//   DEF_*      : default parameter values used by the top level
//   mode_hit() : whether a filtered-level update to 'level' counts as an event
//                in the given mode
// ----------------------------------------------------------------------------
package med_pkg;

  typedef enum logic [1:0] {
    MODE_HIGH = 2'b00,
    MODE_RISE = 2'b01,
    MODE_FALL = 2'b10,
    MODE_BOTH = 2'b11
  } det_mode_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_FILT_W      = 4;

  // HIGH mode only flags an update towards 1, the same as RISE; the two
  // differ in how the detect output is driven, not in what sets status.
  function automatic logic mode_hit(input det_mode_e mode, input logic level);
    case (mode)
      MODE_HIGH: return level;
      MODE_RISE: return level;
      MODE_FALL: return !level;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/med_channel.sv
// ----------------------------------------------------------------------------
// med_channel
// One detector channel: synchroniser chain, debounce filter and mode detector.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : global enable; when low the filter tracks the input silently
//   sig_in     : raw asynchronous input
//   mode       : detection mode for this channel
//   filt_len   : debounce length L (input must disagree for L+1 cycles)
//   evt        : registered detect output (level in HIGH, pulse otherwise)
//   set_pulse  : combinational, high on the edge that should set status
// ----------------------------------------------------------------------------
module med_channel
  import med_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              sig_in,
  input  det_mode_e         mode,
  input  logic [FILT_W-1:0] filt_len,
  output logic              evt,
  output logic              set_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   f_q;
  logic [FILT_W-1:0]      cnt_q;
  logic                   upd;
  logic                   f_nxt;
  logic                   hit;

  assign s = sync_q[SYNC_STAGES-1];

  // '>=' rather than '==' so that shrinking filt_len below a running count
  // still lets the pending update through on the next edge.
  always_comb begin
    upd       = 1'b0;
    f_nxt     = f_q;
    hit       = 1'b0;
    if (!en) begin
      f_nxt = s;
    end else if ((s != f_q) && (cnt_q >= filt_len)) begin
      upd   = 1'b1;
      f_nxt = s;
    end
    hit       = upd && mode_hit(mode, s);
    set_pulse = hit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      f_q    <= 1'b0;
      cnt_q  <= '0;
      evt    <= 1'b0;
    end else begin
      sync_q[0] <= sig_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      f_q <= f_nxt;
      if (!en || (s == f_q) || upd) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
      // HIGH mode follows the post-update level so it shares edge-mode latency.
      if (!en) begin
        evt <= 1'b0;
      end else if (mode == MODE_HIGH) begin
        evt <= f_nxt;
      end else begin
        evt <= hit;
      end
    end
  end

endmodule

// File: rtl/multi_event_detector.sv
// ----------------------------------------------------------------------------
// multi_event_detector
// NUM_CH synchronised, debounced event detectors with sticky status and a
// masked interrupt.
// Ports:
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : global enable
//   i_sig_in     : raw asynchronous inputs, one per channel
//   i_mode       : 2 bits per channel, channel c at [2c+1:2c]
//   i_filt_len   : shared debounce length
//   i_clr        : write-1-to-clear for o_status (a same-cycle set wins)
//   i_int_en     : per-channel interrupt mask
//   o_event      : per-channel registered detect output
//   o_status     : sticky event flags
//   o_irq        : OR of masked status
// ----------------------------------------------------------------------------
module multi_event_detector
  import med_pkg::*;
#(
  parameter int NUM_CH      = DEF_NUM_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int FILT_W      = DEF_FILT_W
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_en,
  input  logic [NUM_CH-1:0]     i_sig_in,
  input  logic [2*NUM_CH-1:0]   i_mode,
  input  logic [FILT_W-1:0]     i_filt_len,
  input  logic [NUM_CH-1:0]     i_clr,
  input  logic [NUM_CH-1:0]     i_int_en,
  output logic [NUM_CH-1:0]     o_event,
  output logic [NUM_CH-1:0]     o_status,
  output logic                  o_irq
);

  logic [NUM_CH-1:0] set_vec;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    med_channel #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILT_W      (FILT_W)
    ) u_ch (
      .clk       (i_clk),
      .rst       (i_rst),
      .en        (i_en),
      .sig_in    (i_sig_in[c]),
      .mode      (det_mode_e'(i_mode[2*c +: 2])),
      .filt_len  (i_filt_len),
      .evt       (o_event[c]),
      .set_pulse (set_vec[c])
    );
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_status <= '0;
    end else begin
      o_status <= (o_status & ~i_clr) | set_vec;
    end
  end

  assign o_irq = |(o_status & i_int_en);

endmodule

// File: tb/tb_multi_event_detector.sv
module tb_multi_event_detector;

  localparam int NUM_CH      = 4;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_W      = 4;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b1;
  logic [NUM_CH-1:0]   sig_in = '0;
  logic [2*NUM_CH-1:0] mode = '0;
  logic [FILT_W-1:0]   filt_len = '0;
  logic [NUM_CH-1:0]   clr = '0;
  logic [NUM_CH-1:0]   int_en = '0;
  logic [NUM_CH-1:0]   evt;
  logic [NUM_CH-1:0]   status;
  logic                irq;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  multi_event_detector #(
    .NUM_CH      (NUM_CH),
    .SYNC_STAGES (SYNC_STAGES),
    .FILT_W      (FILT_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_en       (en),
    .i_sig_in   (sig_in),
    .i_mode     (mode),
    .i_filt_len (filt_len),
    .i_clr      (clr),
    .i_int_en   (int_en),
    .o_event    (evt),
    .o_status   (status),
    .o_irq      (irq)
  );

  // ---------------- reference model ----------------
  // Raw samples reach the filter SYNC_STAGES edges later (delay queue).
  // An update happens when the last L+1 delayed samples, all taken while
  // enabled and since reset, disagree with the filtered level.
  bit                raw_q[NUM_CH][$];
  bit                s_hist[NUM_CH][$];
  bit                en_hist[NUM_CH][$];
  bit                m_f[NUM_CH];
  logic [NUM_CH-1:0] m_event;
  logic [NUM_CH-1:0] m_status;

  always @(posedge clk) begin : ref_model
    bit                s;
    bit                upd;
    bit                hit;
    int                idx;
    int                m;
    logic [NUM_CH-1:0] setv;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        raw_q[c].delete();
        s_hist[c].delete();
        en_hist[c].delete();
        for (int k = 0; k < SYNC_STAGES; k++) raw_q[c].push_back(1'b0);
        m_f[c] = 1'b0;
      end
      m_event  = '0;
      m_status = '0;
    end else begin
      setv = '0;
      for (int c = 0; c < NUM_CH; c++) begin
        s = raw_q[c].pop_front();
        raw_q[c].push_back(sig_in[c]);
        s_hist[c].push_back(s);
        en_hist[c].push_back(en);
        if (s_hist[c].size() > 32) begin
          void'(s_hist[c].pop_front());
          void'(en_hist[c].pop_front());
        end
        upd = 1'b1;
        for (int j = 0; j <= int'(filt_len); j++) begin
          idx = s_hist[c].size() - 1 - j;
          if (idx < 0) upd = 1'b0;
          else if (!en_hist[c][idx] || (s_hist[c][idx] == m_f[c])) upd = 1'b0;
        end
        m = int'(mode[2*c +: 2]);
        hit = 1'b0;
        if (!en) begin
          m_f[c]     = s;
          m_event[c] = 1'b0;
        end else begin
          if (upd) m_f[c] = s;
          case (m)
            0, 1:    hit = upd && s;
            2:       hit = upd && !s;
            default: hit = upd;
          endcase
          m_event[c] = (m == 0) ? m_f[c] : hit;
          setv[c]    = hit;
        end
      end
      m_status = (m_status & ~clr) | setv;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    mode     = 8'b00_00_00_00;
    filt_len = 4'd0;
    int_en   = '1;
    en       = 1'b1;
    sig_in   = '1;
    apply_reset();
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (evt !== 4'b0000) begin errors++; $display("FAIL reset_evt: got %b want 0000", evt); end
    checks++;
    if (status !== 4'b0000) begin errors++; $display("FAIL reset_status: got %b want 0000", status); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst    = 1'b0;
    sig_in = '0;
  endtask

  task automatic test_rise_latency();
    logic exp;
    mode = 8'b00_00_00_01; filt_len = 4'd0; int_en = 4'b0001; sig_in = '0; en = 1'b1;
    apply_reset();
    repeat (10) @(negedge clk);
    sig_in[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp = (i == 2);
      checks++;
      if (evt[0] !== exp) begin errors++; $display("FAIL rise_evt k+%0d: got %b want %b", i, evt[0], exp); end
      exp = (i >= 2);
      checks++;
      if (status[0] !== exp) begin errors++; $display("FAIL rise_status k+%0d: got %b want %b", i, status[0], exp); end
      checks++;
      if (irq !== exp) begin errors++; $display("FAIL rise_irq k+%0d: got %b want %b", i, irq, exp); end
    end
  endtask

  task automatic test_glitch_filter();
    logic exp;
    mode = 8'b00_00_11_00; filt_len = 4'd3; int_en = '0; sig_in = '0; en = 1'b1;
    apply_reset();
    repeat (5) @(negedge clk);
    sig_in[1] = 1'b1;
    repeat (3) @(negedge clk);
    sig_in[1] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if (evt[1] !== 1'b0) begin errors++; $display("FAIL glitch_evt cyc%0d: got %b want 0", i, evt[1]); end
    end
    checks++;
    if (status[1] !== 1'b0) begin errors++; $display("FAIL glitch_status: got %b want 0", status[1]); end
    for (int pass = 0; pass < 2; pass++) begin
      sig_in[1] = (pass == 0);
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        exp = (i == 5);
        checks++;
        if (evt[1] !== exp) begin
          errors++; $display("FAIL both_evt pass%0d k+%0d: got %b want %b", pass, i, evt[1], exp);
        end
      end
    end
    checks++;
    if (status[1] !== 1'b1) begin errors++; $display("FAIL both_status: got %b want 1", status[1]); end
  endtask

  task automatic test_high_level();
    logic exp;
    mode = 8'b01_00_01_01; filt_len = 4'd0; int_en = 4'b0100; sig_in = '0; en = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    sig_in[2] = 1'b1;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      exp = (i >= 2);
      checks++;
      if (evt[2] !== exp) begin errors++; $display("FAIL high_evt k+%0d: got %b want %b", i, evt[2], exp); end
      checks++;
      if (status[2] !== exp) begin errors++; $display("FAIL high_status k+%0d: got %b want %b", i, status[2], exp); end
    end
    clr[2] = 1'b1;
    @(negedge clk);
    clr[2] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (status[2] !== 1'b0) begin errors++; $display("FAIL high_clr_status cyc%0d: got %b want 0", i, status[2]); end
      checks++;
      if (evt[2] !== 1'b1) begin errors++; $display("FAIL high_clr_evt cyc%0d: got %b want 1", i, evt[2]); end
      checks++;
      if (irq !== 1'b0) begin errors++; $display("FAIL high_clr_irq cyc%0d: got %b want 0", i, irq); end
      @(negedge clk);
    end
  endtask

  task automatic test_clr_collision();
    mode = 8'b00_00_00_01; filt_len = 4'd0; int_en = '0; sig_in = '0; en = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    sig_in[0] = 1'b1;
    repeat (2) @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    checks++;
    if (evt[0] !== 1'b1) begin errors++; $display("FAIL collide_evt: got %b want 1", evt[0]); end
    checks++;
    if (status[0] !== 1'b1) begin errors++; $display("FAIL collide_status: got %b want 1", status[0]); end
    @(negedge clk);
    checks++;
    if (status[0] !== 1'b1) begin errors++; $display("FAIL collide_status_hold: got %b want 1", status[0]); end
  endtask

  task automatic test_disable();
    mode = 8'b10_00_00_00; filt_len = 4'd0; int_en = 4'b1000; sig_in = '0; en = 1'b1;
    apply_reset();
    sig_in[3] = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (status[3] !== 1'b0) begin errors++; $display("FAIL dis_pre_status: got %b want 0", status[3]); end
    en = 1'b0;
    sig_in[3] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (evt !== 4'b0000) begin errors++; $display("FAIL dis_evt cyc%0d: got %b want 0000", i, evt); end
    end
    en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (evt[3] !== 1'b0) begin errors++; $display("FAIL reen_evt cyc%0d: got %b want 0", i, evt[3]); end
    end
    checks++;
    if (status[3] !== 1'b0) begin errors++; $display("FAIL reen_status: got %b want 0", status[3]); end
  endtask

  task automatic test_reset_mid_filter();
    logic exp;
    mode = 8'b00_00_00_01; filt_len = 4'd3; int_en = 4'b0001; sig_in = '0; en = 1'b1;
    apply_reset();
    repeat (3) @(negedge clk);
    sig_in[0] = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({evt, status, irq} !== 9'b0) begin
      errors++; $display("FAIL midrst_outputs: got %b/%b/%b want 0/0/0", evt, status, irq);
    end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      exp = (i == 5);
      checks++;
      if (evt[0] !== exp) begin errors++; $display("FAIL midrst_evt e%0d: got %b want %b", i, evt[0], exp); end
    end
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] exp_irq;
    mode = 8'($urandom); filt_len = 4'($urandom_range(3)); int_en = 4'($urandom);
    sig_in = '0; en = 1'b1; clr = '0;
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(5) == 0) sig_in[c] = ~sig_in[c];
        clr[c] = ($urandom_range(7) == 0);
      end
      if ($urandom_range(49) == 0) mode = 8'($urandom);
      if ($urandom_range(59) == 0) filt_len = 4'($urandom_range(3));
      if ($urandom_range(19) == 0) int_en = 4'($urandom);
      if (en && $urandom_range(39) == 0) en = 1'b0;
      else if (!en && $urandom_range(4) == 0) en = 1'b1;
      @(negedge clk);
      exp_irq = m_status & int_en;
      checks++;
      if (evt !== m_event) begin errors++; $display("FAIL rand_evt cyc%0d: got %b want %b", i, evt, m_event); end
      checks++;
      if (status !== m_status) begin errors++; $display("FAIL rand_status cyc%0d: got %b want %b", i, status, m_status); end
      checks++;
      if (irq !== (|exp_irq)) begin errors++; $display("FAIL rand_irq cyc%0d: got %b want %b", i, irq, |exp_irq); end
    end
    clr = '0;
    en  = 1'b1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_rise_latency();
    test_glitch_filter();
    test_high_level();
    test_clr_collision();
    test_disable();
    test_reset_mid_filter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_event_detector.md
Name: multi_event_detector

Overview:
- Parametrised, multi-channel successor to the single-bit level/edge detector used in the APB timer.
- Each channel synchronises an asynchronous input, debounces it with a programmable glitch filter, and detects one of four per-channel modes: high level, rising edge, falling edge or both edges.
- Detected events set sticky, software-clearable status bits that are masked into one interrupt.
- Sits between external/timer trigger pins and the APB register block; the register block drives mode, filter length, enables and clears.

Parameters:
- NUM_CH, 4, number of independent channels (≥1).
- SYNC_STAGES, 2, synchroniser flops per channel (≥1).
- FILT_W, 4, width of the debounce counter and of i_filt_len.

Ports:
- i_clk  input  1  system clock; all logic on its rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_en  input  1  global enable.
- i_sig_in  input  NUM_CH  raw asynchronous inputs, one bit per channel.
- i_mode  input  2*NUM_CH  per-channel mode; channel c uses bits [2c+1:2c]. 00=HIGH, 01=RISE, 10=FALL, 11=BOTH.
- i_filt_len  input  FILT_W  shared debounce length L, 0..2^FILT_W-1.
- i_clr  input  NUM_CH  write-1-to-clear pulses for o_status.
- i_int_en  input  NUM_CH  per-channel interrupt mask.
- o_event  output  NUM_CH  registered detect output; level in HIGH mode, one-cycle pulse otherwise.
- o_status  output  NUM_CH  sticky event flags.
- o_irq  output  1  OR-reduction of (o_status & i_int_en).

Behaviour:
- Reset (i_rst=1 at a clock edge): clear all synchroniser flops, filtered value f, previous-state registers, counters, o_event and o_status; o_irq=0 the cycle after reset.
- Synchroniser: a SYNC_STAGES-deep flop chain per channel; its output is s. Flops run whenever not in reset, independent of i_en.
- Filter, per channel, with counter cnt[FILT_W-1:0]:
  - s==f: cnt<=0.
  - s!=f and cnt==L: f<=s, cnt<=0; this cycle is an "update".
  - s!=f and cnt<L: cnt<=cnt+1.
  - With L=0, f follows s after one edge. A glitch shorter than L+1 cycles at s produces no update.
- Latency: a level first sampled at edge k becomes visible on o_event after edge k+SYNC_STAGES+L.
- Detection, on an update with new value v:
  - RISE: o_event pulses 1 for one cycle when v=1.
  - FALL: o_event pulses 1 for one cycle when v=0.
  - BOTH: o_event pulses 1 for one cycle on either update.
  - HIGH: o_event<=f continuously, registered, so it equals the filtered level.
- Status set condition:
  - Edge modes: set on the same edge as the o_event pulse.
  - HIGH mode: set on an update to 1 only; a held level does not re-set the bit after it is cleared.
  - Set and i_clr in the same cycle: set wins.
  - Otherwise o_status<=o_status & ~i_clr.
- i_en=0: cnt held at 0; f<=s directly, with no events generated. o_event<=0 in every mode. o_status holds but still honours i_clr. On re-enable, no spurious edge is reported for a level that changed while disabled.
- Mode change mid-operation: takes effect on the next edge; no retroactive event. A pulse already registered completes.
- Post-reset: f=0, so an input already high produces a RISE/BOTH/HIGH event after the normal latency.
- i_filt_len change while cnt>0: compare against the new value. If cnt>new L, update on the next edge (use cnt>=L).

Decomposition:
- Package med_pkg:
  - typedef enum logic [1:0] det_mode_e {MODE_HIGH, MODE_RISE, MODE_FALL, MODE_BOTH}.
  - Default parameter constants.
- Sub-module med_channel: one synchroniser, filter and detector per channel; generate NUM_CH instances.
- Top level holds the status register, clear logic and o_irq.

Test Plan:
- Setup for all scenarios: SYNC_STAGES=2, L=0.
- Ch0 RISE, i_sig_in[0] 0→1 at edge 10 → o_event[0]=1 only after edge 12; o_status[0]=1; with i_int_en[0]=1, o_irq=1.
- L=3, ch1 BOTH, 3-cycle high glitch → no event. Then a 4-cycle-stable high → single pulse after edge k+2+3. Fall → second pulse.
- Ch2 HIGH, input held high 20 cycles → o_event[2] high throughout. i_clr[2] pulse → status clears and stays 0 while level remains high.
- i_clr[0]=1 in the same cycle as a RISE event on ch0 → o_status[0] remains 1.
- i_en=0, toggle ch3 (FALL mode) 1→0, then i_en=1 → no o_event[3] and no status set.
- Assert i_rst mid-filter (cnt=2, L=3) → next cycle all outputs 0. Input held high → RISE event exactly 2+L edges after reset deasserts.
